// File: rtl/pipelined_barrel_shifter_if.sv
// Handshake and data bundle for pipelined_barrel_shifter.
//
// Signals:
//   in_valid/in_ready    operation handshake (requester -> shifter)
//   in_data              operand, WIDTH bits
//   in_shamt             shift amount, LOG2W bits (taken modulo WIDTH)
//   in_mode              00 SLL, 01 SRL, 10 SRA, 11 ROL
//   in_tag               sideband carried alongside the operation
//   out_valid/out_ready  result handshake (shifter -> consumer)
//   out_data, out_tag    result and its tag
//   busy                 any pipeline stage holds a valid entry
//
// Modports: master drives operations and consumes results; slave is the shifter.
interface pipelined_barrel_shifter_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LOG2W = 5,
    parameter int unsigned TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [LOG2W-1:0] in_shamt;
    logic [1:0]       in_mode;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    modport master (
        output in_valid, in_data, in_shamt, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, busy
    );

    modport slave (
        input  in_valid, in_data, in_shamt, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, busy
    );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter with valid/ready flow control.
//
// LOG2W cascaded stages, each followed by a register. Stage s applies a shift of
// 2^(LOG2W-1-s) when the matching shift-amount bit is set, so the first stage does
// the largest step and the last stage shifts by one. Modes: SLL, SRL, SRA, ROL.
// A sideband tag travels with each operation. Full throughput (one op per cycle)
// with out_ready high; stalls propagate backwards stage by stage.
//
// Ports:
//   clock   rising-edge clock
//   reset   asynchronous, active-high reset; discards all in-flight operations
//   bus_io  slave side of pipelined_barrel_shifter_if (handshakes, data, tag, busy)
module pipelined_barrel_shifter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LOG2W = 5,
    parameter int unsigned TAG_W = 5
) (
    input logic                       clock,
    input logic                       reset,
    pipelined_barrel_shifter_if.slave bus_io
);

    localparam logic [1:0] ModeSll = 2'b00;
    localparam logic [1:0] ModeSrl = 2'b01;
    localparam logic [1:0] ModeSra = 2'b10;
    localparam logic [1:0] ModeRol = 2'b11;

    // Per-stage registers and their next-state values.
    logic [LOG2W-1:0] valid_q, valid_d;
    logic [WIDTH-1:0] data_q  [LOG2W];
    logic [WIDTH-1:0] data_d  [LOG2W];
    logic [LOG2W-1:0] shamt_q [LOG2W];
    logic [LOG2W-1:0] shamt_d [LOG2W];
    logic [1:0]       mode_q  [LOG2W];
    logic [1:0]       mode_d  [LOG2W];
    logic [TAG_W-1:0] tag_q   [LOG2W];
    logic [TAG_W-1:0] tag_d   [LOG2W];

    logic [LOG2W-1:0] adv;       // stage s hands its entry downstream this cycle
    logic [LOG2W-1:0] down_rdy;  // downstream of stage s can take an entry
    logic [LOG2W-1:0] load;      // stage s captures a new entry this cycle
    logic             in_ready;
    logic             accept;

    // One stage of the shifter: shift/rotate by amt when en is set.
    // SRA replicates the current MSB; every stage preserves the MSB under SRA,
    // so it always equals the operand's original sign bit.
    function automatic logic [WIDTH-1:0] stage_fn(
        input logic [WIDTH-1:0] d,
        input logic             en,
        input logic [1:0]       mode,
        input int unsigned      amt
    );
        logic [WIDTH-1:0] r;
        r = d;
        if (en) begin
            case (mode)
                ModeSll: r = d << amt;
                ModeSrl: r = d >> amt;
                ModeSra: r = $signed(d) >>> amt;
                ModeRol: r = (d << amt) | (d >> (WIDTH - amt));
                default: r = d;
            endcase
        end
        return r;
    endfunction

    // Backward ready chain: the last stage drains on out_ready, every other stage
    // advances when the next one is empty or is itself advancing.
    always_comb begin
        adv      = '0;
        down_rdy = '0;
        down_rdy[LOG2W-1] = bus_io.out_ready;
        adv[LOG2W-1]      = valid_q[LOG2W-1] & bus_io.out_ready;
        for (int s = int'(LOG2W) - 2; s >= 0; s--) begin
            down_rdy[s] = ~valid_q[s+1] | adv[s+1];
            adv[s]      = valid_q[s] & down_rdy[s];
        end
    end

    assign in_ready = ~valid_q[0] | adv[0];
    assign accept   = bus_io.in_valid & in_ready;

    always_comb begin
        load    = '0;
        valid_d = '0;
        for (int s = 0; s < int'(LOG2W); s++) begin
            data_d[s]  = data_q[s];
            shamt_d[s] = shamt_q[s];
            mode_d[s]  = mode_q[s];
            tag_d[s]   = tag_q[s];
        end

        // Stage 0 captures the first-step result of the incoming operand.
        load[0] = accept;
        if (accept) begin
            data_d[0]  = stage_fn(bus_io.in_data, bus_io.in_shamt[LOG2W-1], bus_io.in_mode,
                                  32'd1 << (LOG2W - 1));
            shamt_d[0] = bus_io.in_shamt;
            mode_d[0]  = bus_io.in_mode;
            tag_d[0]   = bus_io.in_tag;
        end

        // Stage s captures the step-s result of stage s-1 when that stage advances.
        for (int s = 1; s < int'(LOG2W); s++) begin
            load[s] = adv[s-1];
            if (adv[s-1]) begin
                data_d[s]  = stage_fn(data_q[s-1], shamt_q[s-1][int'(LOG2W) - 1 - s],
                                      mode_q[s-1], 32'd1 << (int'(LOG2W) - 1 - s));
                shamt_d[s] = shamt_q[s-1];
                mode_d[s]  = mode_q[s-1];
                tag_d[s]   = tag_q[s-1];
            end
        end

        // A stage stays valid unless it drains without being refilled.
        for (int s = 0; s < int'(LOG2W); s++) begin
            valid_d[s] = load[s] | (valid_q[s] & ~adv[s]);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int s = 0; s < int'(LOG2W); s++) begin
                data_q[s]  <= '0;
                shamt_q[s] <= '0;
                mode_q[s]  <= '0;
                tag_q[s]   <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int s = 0; s < int'(LOG2W); s++) begin
                data_q[s]  <= data_d[s];
                shamt_q[s] <= shamt_d[s];
                mode_q[s]  <= mode_d[s];
                tag_q[s]   <= tag_d[s];
            end
        end
    end

    assign bus_io.in_ready  = in_ready;
    assign bus_io.out_valid = valid_q[LOG2W-1];
    assign bus_io.out_data  = data_q[LOG2W-1];
    assign bus_io.out_tag   = tag_q[LOG2W-1];
    assign bus_io.busy      = |valid_q;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
module tb_pipelined_barrel_shifter;

    localparam int unsigned W  = 32;
    localparam int unsigned LW = 5;
    localparam int unsigned TW = 5;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    pipelined_barrel_shifter_if #(.WIDTH(W), .LOG2W(LW), .TAG_W(TW)) bus ();

    pipelined_barrel_shifter #(.WIDTH(W), .LOG2W(LW), .TAG_W(TW)) dut (
        .clock  (clock),
        .reset  (reset),
        .bus_io (bus)
    );

    typedef struct {
        logic [W-1:0]  data;
        logic [TW-1:0] tag;
        int            acc;
    } exp_t;

    typedef struct {
        logic [W-1:0]  data;
        int            shamt;
        logic [1:0]    mode;
        logic [TW-1:0] tag;
        logic [W-1:0]  exp;
    } vec_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    bit   chk_lat = 1'b1;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bit-serial reference: applies the mode one position at a time.
    function automatic logic [W-1:0] model(input logic [W-1:0] d, input int sh,
                                           input logic [1:0] m);
        logic [W-1:0] r;
        r = d;
        for (int i = 0; i < (sh % W); i++) begin
            case (m)
                2'b00:   r = {r[W-2:0], 1'b0};
                2'b01:   r = {1'b0, r[W-1:1]};
                2'b10:   r = {r[W-1], r[W-1:1]};
                default: r = {r[W-2:0], r[W-1]};
            endcase
        end
        return r;
    endfunction

    // Output monitor: scoreboard compare, latency and stall-stability checks.
    logic          stall_q = 1'b0;
    logic [W-1:0]  hold_data;
    logic [TW-1:0] hold_tag;
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset) begin
                stall_q = 1'b0;
            end else begin
                if (stall_q) begin
                    check("stall_valid", bus.out_valid, 1);
                    check("stall_data", bus.out_data, hold_data);
                    check("stall_tag", bus.out_tag, hold_tag);
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_out", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("out_data", bus.out_data, e.data);
                        check("out_tag", bus.out_tag, e.tag);
                        if (chk_lat) check("latency", cyc - e.acc + 1, LW);
                    end
                end
                stall_q   = bus.out_valid && !bus.out_ready;
                hold_data = bus.out_data;
                hold_tag  = bus.out_tag;
            end
        end
    end

    // Present an op; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [W-1:0] d, input int sh, input logic [1:0] m,
                        input logic [TW-1:0] t, input logic [W-1:0] e);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_shamt = LW'(sh);
        bus.in_mode  = m;
        bus.in_tag   = t;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (bus.in_ready) begin
                sb.push_back('{data: e, tag: t, acc: cyc + 1});
                @(posedge clock);
                #1;
                return;
            end
            @(posedge clock);
            #1;
        end
        check("send_timeout", 0, 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clock);
            if (sb.size() == 0) done = 1'b1;
        end
        if (!done) check("drain_timeout", 0, 1);
        @(negedge clock);
        check("idle_out_valid", bus.out_valid, 0);
        check("idle_busy", bus.busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    vec_t          vecs[14];
    logic [W-1:0]  bp_d[8];
    int            bp_sh[8];
    logic [1:0]    bp_m[8];
    int            acc;
    bit            first;
    logic [W-1:0]  rd;
    int            rs;
    logic [1:0]    rm;

    initial begin
        vecs[0]  = '{32'h0000ABCD, 16, 2'b00, 5'd3,  32'hABCD0000};
        vecs[1]  = '{32'h80000000, 31, 2'b10, 5'd4,  32'hFFFFFFFF};
        vecs[2]  = '{32'h80000000, 31, 2'b01, 5'd5,  32'h00000001};
        vecs[3]  = '{32'h7FFFFFFF, 4,  2'b10, 5'd6,  32'h07FFFFFF};
        vecs[4]  = '{32'h80000001, 1,  2'b11, 5'd7,  32'h00000003};
        vecs[5]  = '{32'h12345678, 8,  2'b11, 5'd8,  32'h34567812};
        vecs[6]  = '{32'hDEADBEEF, 0,  2'b00, 5'd9,  32'hDEADBEEF};
        vecs[7]  = '{32'hDEADBEEF, 0,  2'b01, 5'd10, 32'hDEADBEEF};
        vecs[8]  = '{32'hDEADBEEF, 0,  2'b10, 5'd11, 32'hDEADBEEF};
        vecs[9]  = '{32'hDEADBEEF, 0,  2'b11, 5'd12, 32'hDEADBEEF};
        vecs[10] = '{32'hF0000000, 3,  2'b10, 5'd13, 32'hFE000000};
        vecs[11] = '{32'hFFFFFFFF, 31, 2'b00, 5'd14, 32'h80000000};
        vecs[12] = '{32'h0000000F, 31, 2'b11, 5'd15, 32'h80000007};
        vecs[13] = '{32'h12345678, 4,  2'b01, 5'd31, 32'h01234567};

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_shamt  = '0;
        bus.in_mode   = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;

        // Reset state.
        @(posedge clock);
        #2;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_tag", bus.out_tag, 0);
        check("rst_busy", bus.busy, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("rst_in_ready", bus.in_ready, 1);
        @(posedge clock);
        #1;

        // Directed vectors, one at a time.
        chk_lat = 1'b1;
        foreach (vecs[i]) begin
            send(vecs[i].data, vecs[i].shamt, vecs[i].mode, vecs[i].tag, vecs[i].exp);
            idle();
            wait_drain();
            @(posedge clock);
            #1;
        end

        // Backpressure: 8 back-to-back ops into a stalled pipe.
        chk_lat = 1'b0;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            bp_d[k]  = $urandom;
            bp_sh[k] = k * 3 + 1;
            bp_m[k]  = 2'(k % 4);
        end
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = bp_d[acc];
            bus.in_shamt = LW'(bp_sh[acc]);
            bus.in_mode  = bp_m[acc];
            bus.in_tag   = TW'(acc);
            @(negedge clock);
            if (bus.in_ready) begin
                sb.push_back('{data: model(bp_d[acc], bp_sh[acc], bp_m[acc]),
                               tag: TW'(acc), acc: cyc + 1});
                acc++;
            end
            @(posedge clock);
            #1;
        end
        check("bp_accepts", acc, LW);
        @(negedge clock);
        check("bp_in_ready", bus.in_ready, 0);
        check("bp_out_valid", bus.out_valid, 1);
        check("bp_head_tag", bus.out_tag, 0);
        @(posedge clock);
        #1;
        bus.out_ready = 1'b1;
        first = 1'b1;
        for (int c = 0; c < 20 && acc < 8; c++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = bp_d[acc];
            bus.in_shamt = LW'(bp_sh[acc]);
            bus.in_mode  = bp_m[acc];
            bus.in_tag   = TW'(acc);
            @(negedge clock);
            if (first) check("full_pipe_in_ready", bus.in_ready, 1);
            first = 1'b0;
            if (bus.in_ready) begin
                sb.push_back('{data: model(bp_d[acc], bp_sh[acc], bp_m[acc]),
                               tag: TW'(acc), acc: cyc + 1});
                acc++;
            end
            @(posedge clock);
            #1;
        end
        check("bp_total_accepts", acc, 8);
        idle();
        wait_drain();
        @(posedge clock);
        #1;

        // Full throughput: 20 random back-to-back ops.
        chk_lat = 1'b1;
        for (int k = 0; k < 20; k++) begin
            rd = $urandom;
            rs = $urandom_range(0, W - 1);
            rm = 2'($urandom_range(0, 3));
            send(rd, rs, rm, TW'(k), model(rd, rs, rm));
        end
        idle();
        wait_drain();
        @(posedge clock);
        #1;

        // Reset with three ops in flight.
        for (int k = 0; k < 3; k++) begin
            rd = $urandom;
            send(rd, k + 2, 2'b00, TW'(20 + k), model(rd, k + 2, 2'b00));
        end
        idle();
        check("pre_rst_busy", bus.busy, 1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_out_data", bus.out_data, 0);
        sb.delete();
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (8) @(negedge clock);
        check("post_rst_busy", bus.busy, 0);
        check("post_rst_out_valid", bus.out_valid, 0);
        @(posedge clock);
        #1;
        send(32'hCAFE0001, 12, 2'b11, 5'd30, model(32'hCAFE0001, 12, 2'b11));
        idle();
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
